// File: rtl/operand_fetch_pkg.sv
// cpu_defs: register-class encoding and datapath widths shared by the operand fetch stage and the register file
package cpu_defs;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam logic [DATA_W-1:0] ZERO = '0;
  typedef enum logic [2:0] {
    CLS_NOP = 3'd0,
    CLS_REG = 3'd1,
    CLS_T   = 3'd2,
    CLS_SP  = 3'd3,
    CLS_IH  = 3'd4,
    CLS_RA  = 3'd5
  } reg_class_e;
endpackage

// File: rtl/operand_fetch_if.sv
// operand_fetch_if: decode-stage request and ID/EX latch bundle of the operand fetch stage
interface operand_fetch_if #(
  parameter int DATA_W = cpu_defs::DATA_W,
  parameter int ADDR_W = cpu_defs::ADDR_W
);
  logic              id_valid;
  logic [2:0]        id_src_a_op, id_src_b_op, id_dst_op;
  logic [ADDR_W-1:0] id_src_a_addr, id_src_b_addr, id_dst_addr;
  logic              id_is_load;
  logic              flush;
  logic              stall;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_op_a, ex_op_b;
  logic [2:0]        ex_dst_op;
  logic [ADDR_W-1:0] ex_dst_addr;
  logic              ex_is_load;
  modport master (
    output id_valid, id_src_a_op, id_src_b_op, id_dst_op, id_src_a_addr, id_src_b_addr,
           id_dst_addr, id_is_load, flush,
    input  stall, ex_valid, ex_op_a, ex_op_b, ex_dst_op, ex_dst_addr, ex_is_load
  );
  modport slave (
    input  id_valid, id_src_a_op, id_src_b_op, id_dst_op, id_src_a_addr, id_src_b_addr,
           id_dst_addr, id_is_load, flush,
    output stall, ex_valid, ex_op_a, ex_op_b, ex_dst_op, ex_dst_addr, ex_is_load
  );
endinterface

// File: rtl/operand_fetch_fwd_mux.sv
// fwd_mux: producer match and EXE > MEM > WB > register-file select for one source operand
module fwd_mux #(
  parameter int DATA_W = cpu_defs::DATA_W,
  parameter int ADDR_W = cpu_defs::ADDR_W
) (
  input  logic [2:0]        src_op,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0] rf_reg,
  input  logic [DATA_W-1:0] rf_t,
  input  logic [DATA_W-1:0] rf_sp,
  input  logic [DATA_W-1:0] rf_ih,
  input  logic [DATA_W-1:0] rf_ra,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic [2:0]        ex_op,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] exe_res,
  input  logic [2:0]        mem_op,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_rdy,
  input  logic [2:0]        wb_op,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] val,
  output logic              hazard
);
  import cpu_defs::*;
  logic ex_hit, mem_hit, wb_hit;
  logic [DATA_W-1:0] rf_val;
  function automatic logic hit(input logic [2:0] s_op, input logic [ADDR_W-1:0] s_addr,
                               input logic [2:0] p_op, input logic [ADDR_W-1:0] p_addr);
    return s_op == p_op && s_op != CLS_NOP && (s_op != CLS_REG || s_addr == p_addr);
  endfunction
  assign ex_hit  = ex_valid && hit(src_op, src_addr, ex_op, ex_addr);
  assign mem_hit = hit(src_op, src_addr, mem_op, mem_addr);
  assign wb_hit  = hit(src_op, src_addr, wb_op, wb_addr);
  assign rf_val  = src_op == CLS_REG ? rf_reg :
                   src_op == CLS_T   ? rf_t   :
                   src_op == CLS_SP  ? rf_sp  :
                   src_op == CLS_IH  ? rf_ih  :
                   src_op == CLS_RA  ? rf_ra  : ZERO;
  // a load in EXE has no result yet; its match only raises the hazard
  assign val     = ex_hit && !ex_is_load ? exe_res  :
                   mem_hit               ? mem_data :
                   wb_hit                ? wb_data  : rf_val;
  assign hazard  = (ex_hit && ex_is_load) || (mem_hit && !mem_rdy);
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: forwards operands into the ID/EX latch, stalling on load-use and pending MEM results
module operand_fetch #(
  parameter int DATA_W = cpu_defs::DATA_W,
  parameter int ADDR_W = cpu_defs::ADDR_W
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  operand_fetch_if.slave    bus,
  output logic [ADDR_W-1:0] A_addr,
  output logic [ADDR_W-1:0] B_addr,
  input  logic [DATA_W-1:0] rf_A,
  input  logic [DATA_W-1:0] rf_B,
  input  logic [DATA_W-1:0] rf_T,
  input  logic [DATA_W-1:0] rf_SP,
  input  logic [DATA_W-1:0] rf_IH,
  input  logic [DATA_W-1:0] rf_RA,
  input  logic [DATA_W-1:0] exe_res,
  input  logic [2:0]        mem_op,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_rdy,
  input  logic [2:0]        wb_op,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [15:0]       stall_cnt
);
  import cpu_defs::*;
  logic haz_a, haz_b, hazard, bubble;
  logic [DATA_W-1:0] op_a, op_b;
  fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_a (
    .src_op(bus.id_src_a_op), .src_addr(bus.id_src_a_addr), .rf_reg(rf_A),
    .rf_t(rf_T), .rf_sp(rf_SP), .rf_ih(rf_IH), .rf_ra(rf_RA),
    .ex_valid(bus.ex_valid), .ex_is_load(bus.ex_is_load), .ex_op(bus.ex_dst_op),
    .ex_addr(bus.ex_dst_addr), .exe_res(exe_res),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_data(mem_data), .mem_rdy(mem_rdy),
    .wb_op(wb_op), .wb_addr(wb_addr), .wb_data(wb_data),
    .val(op_a), .hazard(haz_a)
  );
  fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_b (
    .src_op(bus.id_src_b_op), .src_addr(bus.id_src_b_addr), .rf_reg(rf_B),
    .rf_t(rf_T), .rf_sp(rf_SP), .rf_ih(rf_IH), .rf_ra(rf_RA),
    .ex_valid(bus.ex_valid), .ex_is_load(bus.ex_is_load), .ex_op(bus.ex_dst_op),
    .ex_addr(bus.ex_dst_addr), .exe_res(exe_res),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_data(mem_data), .mem_rdy(mem_rdy),
    .wb_op(wb_op), .wb_addr(wb_addr), .wb_data(wb_data),
    .val(op_b), .hazard(haz_b)
  );
  assign A_addr    = bus.id_src_a_addr;
  assign B_addr    = bus.id_src_b_addr;
  assign hazard    = bus.id_valid && (haz_a || haz_b);
  assign bus.stall = hazard && !bus.flush;
  assign bubble    = bus.flush || hazard || !bus.id_valid;
  always_ff @(posedge clk_50MHz or negedge rst)
    if (!rst) begin
      bus.ex_valid    <= 1'b0;
      bus.ex_op_a     <= '0;
      bus.ex_op_b     <= '0;
      bus.ex_dst_op   <= CLS_NOP;
      bus.ex_dst_addr <= '0;
      bus.ex_is_load  <= 1'b0;
      stall_cnt       <= '0;
    end else begin
      stall_cnt       <= stall_cnt + 16'(bus.stall);
      bus.ex_valid    <= !bubble;
      bus.ex_op_a     <= bubble ? '0 : op_a;
      bus.ex_op_b     <= bubble ? '0 : op_b;
      bus.ex_dst_op   <= bubble ? CLS_NOP : bus.id_dst_op;
      bus.ex_dst_addr <= bubble ? '0 : bus.id_dst_addr;
      bus.ex_is_load  <= !bubble && bus.id_is_load;
    end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed scenarios then random traffic against a rule-level model of the fetch stage
module tb_operand_fetch;
  import cpu_defs::*;
  logic        clk_50MHz = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  A_addr, B_addr, mem_op, mem_addr, wb_op, wb_addr;
  logic [15:0] rf_A, rf_B, rf_T, rf_SP, rf_IH, rf_RA, exe_res, mem_data, wb_data, stall_cnt;
  logic        mem_rdy;
  int          checks = 0, errors = 0;
  logic        m_valid, m_load;
  logic [15:0] m_a, m_b, m_cnt;
  logic [2:0]  m_dop, m_daddr;

  operand_fetch_if #(.DATA_W(16), .ADDR_W(3)) bus();

  operand_fetch #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk_50MHz(clk_50MHz), .rst(rst), .bus(bus), .A_addr(A_addr), .B_addr(B_addr),
    .rf_A(rf_A), .rf_B(rf_B), .rf_T(rf_T), .rf_SP(rf_SP), .rf_IH(rf_IH), .rf_RA(rf_RA),
    .exe_res(exe_res), .mem_op(mem_op), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_rdy(mem_rdy), .wb_op(wb_op), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall_cnt(stall_cnt)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic same(input logic [2:0] so, input logic [2:0] sa,
                                input logic [2:0] po, input logic [2:0] pa);
    return so != CLS_NOP && so == po && (so != CLS_REG || sa == pa);
  endfunction

  function automatic logic blocked(input logic [2:0] so, input logic [2:0] sa);
    return (m_valid && m_load && same(so, sa, m_dop, m_daddr)) ||
           (!mem_rdy && same(so, sa, mem_op, mem_addr));
  endfunction

  function automatic logic [15:0] fetch(input logic [2:0] so, input logic [2:0] sa,
                                        input logic [15:0] rf_gen);
    logic        pen [3];
    logic [2:0]  pop [3];
    logic [2:0]  pad [3];
    logic [15:0] pdat [3];
    logic [15:0] by_class [8];
    pen  = '{m_valid && !m_load, 1'b1, 1'b1};
    pop  = '{m_dop, mem_op, wb_op};
    pad  = '{m_daddr, mem_addr, wb_addr};
    pdat = '{exe_res, mem_data, wb_data};
    by_class = '{16'h0, rf_gen, rf_T, rf_SP, rf_IH, rf_RA, 16'h0, 16'h0};
    for (int i = 0; i < 3; i++)
      if (pen[i] && same(so, sa, pop[i], pad[i])) return pdat[i];
    return by_class[so];
  endfunction

  task automatic model_reset();
    m_valid = 0; m_load = 0; m_a = 0; m_b = 0; m_dop = CLS_NOP; m_daddr = 0; m_cnt = 0;
  endtask

  task automatic idle_prod();
    exe_res = 0; mem_op = CLS_NOP; mem_addr = 0; mem_data = 0; mem_rdy = 1;
    wb_op = CLS_NOP; wb_addr = 0; wb_data = 0;
  endtask

  task automatic set_id(input logic v, input logic [2:0] aop, input logic [2:0] aad,
                        input logic [2:0] bop, input logic [2:0] bad,
                        input logic [2:0] dop, input logic [2:0] dad,
                        input logic ld, input logic fl);
    bus.id_valid = v; bus.id_src_a_op = aop; bus.id_src_a_addr = aad;
    bus.id_src_b_op = bop; bus.id_src_b_addr = bad;
    bus.id_dst_op = dop; bus.id_dst_addr = dad; bus.id_is_load = ld; bus.flush = fl;
  endtask

  // inputs already applied; checks the combinational stall, then the latch one edge later
  task automatic step();
    logic        hz, bub;
    logic [15:0] na, nb;
    #1;
    hz  = bus.id_valid && (blocked(bus.id_src_a_op, bus.id_src_a_addr) ||
                           blocked(bus.id_src_b_op, bus.id_src_b_addr));
    bub = bus.flush || hz || !bus.id_valid;
    na  = fetch(bus.id_src_a_op, bus.id_src_a_addr, rf_A);
    nb  = fetch(bus.id_src_b_op, bus.id_src_b_addr, rf_B);
    chk("stall", bus.stall, hz && !bus.flush);
    chk("A_addr", A_addr, bus.id_src_a_addr);
    chk("B_addr", B_addr, bus.id_src_b_addr);
    if (hz && !bus.flush) m_cnt++;
    m_valid = !bub;
    m_a     = bub ? 16'h0 : na;
    m_b     = bub ? 16'h0 : nb;
    m_dop   = bub ? 3'(CLS_NOP) : bus.id_dst_op;
    m_daddr = bub ? 3'h0 : bus.id_dst_addr;
    m_load  = !bub && bus.id_is_load;
    @(posedge clk_50MHz);
    #1;
    chk("ex_valid", bus.ex_valid, m_valid);
    chk("ex_op_a", bus.ex_op_a, m_a);
    chk("ex_op_b", bus.ex_op_b, m_b);
    chk("ex_dst_op", bus.ex_dst_op, m_dop);
    chk("ex_dst_addr", bus.ex_dst_addr, m_daddr);
    chk("ex_is_load", bus.ex_is_load, m_load);
    chk("stall_cnt", stall_cnt, m_cnt);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ex_valid"}, bus.ex_valid, 0);
    chk({tag, "_ex_op_a"}, bus.ex_op_a, 0);
    chk({tag, "_ex_op_b"}, bus.ex_op_b, 0);
    chk({tag, "_ex_dst_op"}, bus.ex_dst_op, CLS_NOP);
    chk({tag, "_ex_dst_addr"}, bus.ex_dst_addr, 0);
    chk({tag, "_ex_is_load"}, bus.ex_is_load, 0);
    chk({tag, "_stall_cnt"}, stall_cnt, 0);
  endtask

  initial begin
    rf_A = 16'hA0A0; rf_B = 16'hB0B0; rf_T = 16'h7777; rf_SP = 16'h0000;
    rf_IH = 16'h1111; rf_RA = 16'h2222;
    idle_prod();
    set_id(0, CLS_NOP, 0, CLS_NOP, 0, CLS_NOP, 0, 0, 0);
    model_reset();
    #5;
    chk_reset_state("reset");
    #10 rst = 1'b1;

    // EXE forwarding of an ALU result
    set_id(1, CLS_NOP, 0, CLS_NOP, 0, CLS_REG, 1, 0, 0);
    step();
    exe_res = 16'h0005;
    set_id(1, CLS_REG, 1, CLS_NOP, 0, CLS_REG, 4, 0, 0);
    step();
    chk("alu_fwd_op_a", bus.ex_op_a, 16'h0005);

    // load-use: one stall for EXE, further stall while MEM not ready
    idle_prod();
    set_id(1, CLS_NOP, 0, CLS_NOP, 0, CLS_REG, 2, 1, 0);
    step();
    set_id(1, CLS_REG, 2, CLS_NOP, 0, CLS_REG, 5, 0, 0);
    #1 chk("load_use_stall", bus.stall, 1);
    step();
    chk("load_use_bubble", bus.ex_valid, 0);
    chk("load_use_cnt", stall_cnt, 1);
    mem_op = CLS_REG; mem_addr = 2; mem_data = 16'h1234; mem_rdy = 0;
    step();
    chk("mem_wait_cnt", stall_cnt, 2);
    mem_rdy = 1;
    step();
    chk("mem_fwd_op_a", bus.ex_op_a, 16'h1234);

    // same-cycle write-back of SP
    idle_prod();
    wb_op = CLS_SP; wb_data = 16'hBEEF;
    set_id(1, CLS_NOP, 0, CLS_SP, 0, CLS_NOP, 0, 0, 0);
    step();
    chk("wb_fwd_op_b", bus.ex_op_b, 16'hBEEF);

    // hazard with flush: flush wins
    idle_prod();
    set_id(1, CLS_NOP, 0, CLS_NOP, 0, CLS_REG, 2, 1, 0);
    step();
    set_id(1, CLS_REG, 2, CLS_NOP, 0, CLS_REG, 5, 0, 1);
    #1 chk("flush_stall", bus.stall, 0);
    step();
    chk("flush_bubble", bus.ex_valid, 0);

    // priority EXE > MEM > WB, then class mismatch
    set_id(1, CLS_NOP, 0, CLS_NOP, 0, CLS_REG, 3, 0, 0);
    step();
    exe_res = 16'h0001;
    mem_op = CLS_REG; mem_addr = 3; mem_data = 16'h0002; mem_rdy = 1;
    wb_op = CLS_REG; wb_addr = 3; wb_data = 16'h0003;
    set_id(1, CLS_REG, 3, CLS_NOP, 0, CLS_REG, 3, 0, 0);
    step();
    chk("prio_op_a", bus.ex_op_a, 16'h0001);
    mem_op = CLS_NOP; wb_op = CLS_NOP;
    set_id(1, CLS_T, 3, CLS_NOP, 0, CLS_NOP, 0, 0, 0);
    step();
    chk("class_mismatch_op_a", bus.ex_op_a, 16'h7777);

    // reset in the middle of a stall
    idle_prod();
    set_id(1, CLS_NOP, 0, CLS_NOP, 0, CLS_REG, 2, 1, 0);
    step();
    set_id(1, CLS_REG, 2, CLS_NOP, 0, CLS_REG, 5, 0, 0);
    #1 chk("pre_reset_stall", bus.stall, 1);
    rst = 1'b0;
    #1;
    model_reset();
    chk_reset_state("mid_reset");
    chk("mid_reset_stall", bus.stall, 0);
    rst = 1'b1;
    step();
    chk("post_reset_valid", bus.ex_valid, 1);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      rf_A = 16'($urandom); rf_B = 16'($urandom); rf_T = 16'($urandom);
      rf_SP = 16'($urandom); rf_IH = 16'($urandom); rf_RA = 16'($urandom);
      exe_res = 16'($urandom); mem_data = 16'($urandom); wb_data = 16'($urandom);
      mem_op = 3'($urandom_range(5, 0)); mem_addr = 3'($urandom_range(3, 0));
      mem_rdy = ($urandom_range(3, 0) != 0);
      wb_op = 3'($urandom_range(5, 0)); wb_addr = 3'($urandom_range(3, 0));
      set_id($urandom_range(7, 0) != 0,
             3'($urandom_range(5, 0)), 3'($urandom_range(3, 0)),
             3'($urandom_range(5, 0)), 3'($urandom_range(3, 0)),
             3'($urandom_range(5, 0)), 3'($urandom_range(3, 0)),
             $urandom_range(2, 0) == 0, $urandom_range(7, 0) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
